round_sequencer: RTL

Game-flow controller for the Finger Dancer datapath. Each round it draws a 4-bit target pattern from an internal LFSR and opens a timed input window paced by an external `tick` enable. It judges the synchronized `SW` inputs against the target, then updates round count, score and miss count, and ends the game after a fixed number of rounds or too many misses. It sits between the clock divider (which supplies `tick`) and the LED/7-segment display logic (which consumes `pattern`, `roundres`, `count`, `score` and `time_left`).

---
 rtl/finger_pkg.sv | 18 +
 rtl/round_sequencer_lfsr8.sv | 16 +
 rtl/round_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/finger_pkg.sv
// finger_pkg: shared state encoding, LFSR taps and pattern constants for the Finger Dancer sequencer.
package finger_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PLAY   = 3'd2,
        S_JUDGE  = 3'd3,
        S_RESULT = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [3:0] ZERO_SUB  = 4'b1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/round_sequencer_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, advanced once per step pulse.
module lfsr8
    import finger_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       board_clk,
    input  logic       rst_btn,
    input  logic       step,
    output logic [7:0] q
);
    always_ff @(posedge board_clk or posedge rst_btn) begin
        if (rst_btn) q <= SEED;
        else if (step) q <= lfsr_next(q);
    end
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: per-round target draw, timed input window, judging and score/miss bookkeeping.
module round_sequencer
    import finger_pkg::*;
#(
    parameter int         ROUNDS       = 10,
    parameter int         ROUND_TICKS  = 8,
    parameter int         RESULT_TICKS = 2,
    parameter int         MAX_MISSES   = 3,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic       board_clk,
    input  logic       rst_btn,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] SW,
    output logic [3:0] pattern,
    output logic       game,
    output logic [3:0] count,
    output logic       roundres,
    output logic       cout,
    output logic [7:0] score,
    output logic [3:0] time_left
);
    state_t     r_state, w_next;
    logic [3:0] r_sync, r_sw_s, r_pattern, r_count, r_time_left, r_misses;
    logic [7:0] r_score, r_hold, w_lfsr;
    logic       r_armed, r_hit, r_roundres, r_cout;
    logic       w_match, w_hit_now, w_miss_now, w_hold_done, w_end, w_unused;
    logic [8:0] w_sum;
    logic [7:0] w_score_sat;
    logic [3:0] w_draw;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .board_clk(board_clk),
        .rst_btn  (rst_btn),
        .step     (w_next == S_LOAD),
        .q        (w_lfsr)
    );

    assign w_unused    = ^w_lfsr[7:4];
    assign w_draw      = (w_lfsr[3:0] == 4'd0) ? ZERO_SUB : w_lfsr[3:0];
    assign w_match     = r_sw_s == r_pattern;
    assign w_hit_now   = r_state == S_PLAY && r_armed && w_match;
    assign w_miss_now  = r_state == S_PLAY && !w_hit_now && tick && r_time_left == 4'd0;
    assign w_hold_done = r_state == S_RESULT && tick && r_hold == 8'(RESULT_TICKS - 1);
    assign w_end       = r_count == 4'(ROUNDS) || r_misses == 4'(MAX_MISSES);
    assign w_sum       = {1'b0, r_score} + {5'd0, r_time_left} + 9'd1;
    assign w_score_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

    assign pattern   = r_pattern;
    assign game      = r_state inside {S_LOAD, S_PLAY, S_JUDGE, S_RESULT};
    assign count     = r_count;
    assign roundres  = r_roundres;
    assign cout      = r_cout;
    assign score     = r_score;
    assign time_left = r_time_left;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_OVER: w_next = start ? S_LOAD : r_state;
            S_LOAD:         w_next = S_PLAY;
            S_PLAY:         w_next = (w_hit_now || w_miss_now) ? S_JUDGE : S_PLAY;
            S_JUDGE:        w_next = S_RESULT;
            S_RESULT:       w_next = w_hold_done ? (w_end ? S_OVER : S_LOAD) : S_RESULT;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge board_clk or posedge rst_btn) begin
        if (rst_btn) begin
            r_state     <= S_IDLE;
            r_sync      <= 4'd0;
            r_sw_s      <= 4'd0;
            r_pattern   <= 4'd0;
            r_count     <= 4'd0;
            r_time_left <= 4'd0;
            r_misses    <= 4'd0;
            r_score     <= 8'd0;
            r_hold      <= 8'd0;
            r_armed     <= 1'b0;
            r_hit       <= 1'b0;
            r_roundres  <= 1'b0;
            r_cout      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync  <= SW;
            r_sw_s  <= r_sync;
            r_cout  <= r_state == S_JUDGE;
            unique case (r_state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        r_count    <= 4'd0;
                        r_score    <= 8'd0;
                        r_misses   <= 4'd0;
                        r_roundres <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_pattern   <= w_draw;
                    r_time_left <= 4'(ROUND_TICKS - 1);
                    r_armed     <= 1'b0;
                end
                S_PLAY: begin
                    // a switch setting carried over from the last round only counts after it has differed once
                    if (!w_match) r_armed <= 1'b1;
                    r_hit <= w_hit_now;
                    if (!w_hit_now && tick && r_time_left != 4'd0) r_time_left <= r_time_left - 4'd1;
                end
                S_JUDGE: begin
                    r_roundres <= r_hit;
                    r_count    <= r_count + 4'd1;
                    r_hold     <= 8'd0;
                    if (r_hit) r_score <= w_score_sat;
                    else r_misses <= r_misses + 4'd1;
                end
                S_RESULT: begin
                    if (tick) r_hold <= r_hold + 8'd1;
                    if (w_hold_done && w_end) r_pattern <= 4'd0;
                end
                default: ;
            endcase
        end
    end
endmodule
